// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op-vector bit positions, stage state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int ALU_SIG_W = 13;

  // Bit positions inside the one-hot alusignals vector
  localparam int ALU_ADD = 0;
  localparam int ALU_LD  = 1;
  localparam int ALU_ST  = 2;
  localparam int ALU_SUB = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_OR  = 5;
  localparam int ALU_SLL = 6;
  localparam int ALU_SRL = 7;
  localparam int ALU_SRA = 8;
  localparam int ALU_SLT = 9;
  localparam int ALU_BEQ = 10;
  localparam int ALU_JMP = 11;
  localparam int ALU_XOR = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Any op that needs the data memory (a load wins if both bits are set)
  function automatic logic is_mem_op(input logic [ALU_SIG_W-1:0] sig);
    return sig[ALU_LD] | sig[ALU_ST];
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for an outstanding memory request: clear, count, flag the last allowed cycle.
// Latency: expire is combinational from the count; count updates on the clock edge.
// Backpressure: none; the owner decides when to clear and enable.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Cycle counter; clear has priority so a fresh access always starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: passes ALU results to writeback, or performs a req/ack data-memory access.
// Latency: 1 cycle for non-memory ops; 2+n cycles for loads/stores acked after n wait cycles.
// Backpressure: in_ready drops for the whole access; writeback is a pulse with no backpressure.
module mem_access_stage #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [cpu_pkg::ALU_SIG_W-1:0] in_alusignals,
  input  logic [DATA_W-1:0]             in_result,
  input  logic [DATA_W-1:0]             in_stdata,
  input  logic [cpu_pkg::REG_IDX_W-1:0] in_rd,
  input  logic                          in_wben,
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [ADDR_W-1:0]             dmem_addr,
  output logic [DATA_W-1:0]             dmem_wdata,
  input  logic                          dmem_ack,
  input  logic [DATA_W-1:0]             dmem_rdata,
  output logic                          wb_valid,
  output logic                          wb_en,
  output logic [cpu_pkg::REG_IDX_W-1:0] wb_rd,
  output logic [DATA_W-1:0]             wb_data,
  output logic                          err
);

  import cpu_pkg::*;

  state_t                 r_state,    w_state_nxt;
  logic                   r_req,      w_req_nxt;
  logic                   r_we,       w_we_nxt;
  logic [ADDR_W-1:0]      r_addr,     w_addr_nxt;
  logic [DATA_W-1:0]      r_wdata,    w_wdata_nxt;
  logic                   r_wb_valid, w_wb_valid_nxt;
  logic                   r_wb_en,    w_wb_en_nxt;
  logic [REG_IDX_W-1:0]   r_wb_rd,    w_wb_rd_nxt;
  logic [DATA_W-1:0]      r_wb_data,  w_wb_data_nxt;
  logic                   r_err,      w_err_nxt;

  logic w_is_ld;
  logic w_is_mem;
  logic w_ctr_clr;
  logic w_ctr_en;
  logic w_expire;
  logic w_unused_bits;

  assign w_is_ld  = in_alusignals[ALU_LD];
  assign w_is_mem = is_mem_op(in_alusignals);

  // Only the ld/st bits steer this stage; the rest of the op vector is intentionally ignored
  assign w_unused_bits = ^in_alusignals;

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_ctr_clr),
    .i_en     (w_ctr_en),
    .o_expire (w_expire)
  );

  // Next-state and next-output decode; everything defaults to hold except the retire pulse
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_wb_valid_nxt = 1'b0;
    w_wb_en_nxt    = r_wb_en;
    w_wb_rd_nxt    = r_wb_rd;
    w_wb_data_nxt  = r_wb_data;
    w_err_nxt      = r_err;
    w_ctr_clr      = 1'b0;
    w_ctr_en       = 1'b0;

    case (r_state)
      IDLE: begin
        // A stray ack here is ignored: nothing is outstanding
        if (in_valid) begin
          w_wb_rd_nxt = in_rd;
          if (w_is_mem) begin
            w_addr_nxt  = in_result[ADDR_W-1:0];
            w_wdata_nxt = in_stdata;
            w_we_nxt    = ~w_is_ld;
            w_req_nxt   = 1'b1;
            w_ctr_clr   = 1'b1;
            w_state_nxt = ACCESS;
          end else begin
            w_wb_valid_nxt = 1'b1;
            w_wb_en_nxt    = in_wben;
            w_wb_data_nxt  = in_result;
          end
        end
      end
      ACCESS: begin
        w_ctr_en = 1'b1;
        // An ack on the final allowed cycle still counts as a completed access
        if (dmem_ack) begin
          w_req_nxt      = 1'b0;
          w_wb_valid_nxt = 1'b1;
          w_wb_en_nxt    = ~r_we;
          w_wb_data_nxt  = r_we ? '0 : dmem_rdata;
          w_state_nxt    = IDLE;
        end else if (w_expire) begin
          w_req_nxt      = 1'b0;
          w_err_nxt      = 1'b1;
          w_wb_valid_nxt = 1'b1;
          w_wb_en_nxt    = 1'b0;
          w_wb_data_nxt  = '0;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access and drops the request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_wb_en    <= w_wb_en_nxt;
      r_wb_rd    <= w_wb_rd_nxt;
      r_wb_data  <= w_wb_data_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_en      = r_wb_en;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops against a word-array memory model.
// Latency: checks 1-cycle ALU retire and 2+n-cycle memory retire.
// Backpressure: checks in_ready low during access and the access timeout.
module tb_mem_access_stage;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int TMO = 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [12:0]   in_alusignals;
  logic [DW-1:0] in_result;
  logic [DW-1:0] in_stdata;
  logic [2:0]    in_rd;
  logic          in_wben;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid;
  logic          wb_en;
  logic [2:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          err;

  int vecs;
  int miscompares;

  logic [DW-1:0] mem_model [0:(1<<AW)-1];

  mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alusignals (in_alusignals),
    .in_result     (in_result),
    .in_stdata     (in_stdata),
    .in_rd         (in_rd),
    .in_wben       (in_wben),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_alusignals = '0; in_result = '0; in_stdata = '0;
    in_rd = '0; in_wben = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    #3;
    vecs++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_en, wb_rd, wb_data, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h wbv=%b wbe=%b rd=%0d wbd=%h err=%b, want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_en, wb_rd, wb_data, err);
    end
    #19 rst_n = 1'b1;
    tick();
    vecs++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b wb_valid=%b, want 1 0", in_ready, wb_valid);
    end
  endtask

  task automatic test_alu;
    in_valid = 1'b1; in_alusignals = 13'(1 << 0); in_result = 16'h0012; in_rd = 3'd3; in_wben = 1'b1;
    tick();
    // second op back to back: xor without writeback enable
    in_alusignals = 13'(1 << 12); in_result = 16'h7E01; in_rd = 3'd6; in_wben = 1'b0;
    vecs++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 3'd3, 16'h0012} || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_add: got v=%b en=%b rd=%0d d=%h rdy=%b, want 1 1 3 0012 1",
               wb_valid, wb_en, wb_rd, wb_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vecs++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {1'b1, 1'b0, 3'd6, 16'h7E01}) begin
      miscompares++;
      $display("FAIL alu_xor: got v=%b en=%b rd=%0d d=%h, want 1 0 6 7e01", wb_valid, wb_en, wb_rd, wb_data);
    end
    tick();
    vecs++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_pulse: got wb_valid=%b, want 0", wb_valid);
    end
  endtask

  task automatic test_load;
    in_valid = 1'b1; in_alusignals = 13'(1 << 1); in_result = 16'h0140; in_stdata = 16'h1111;
    in_rd = 3'd5; in_wben = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (dmem_req !== 1'b1 || dmem_addr !== 8'h40 || dmem_we !== 1'b0 || in_ready !== 1'b0 || wb_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL load_req_cycle%0d: got req=%b addr=%h we=%b rdy=%b wbv=%b, want 1 40 0 0 0",
                 i, dmem_req, dmem_addr, dmem_we, in_ready, wb_valid);
      end
      if (i == 3) begin
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
      end
      tick();
    end
    dmem_ack = 1'b0;
    vecs++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 3'd5, 16'hBEEF} || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_retire: got v=%b en=%b rd=%0d d=%h req=%b rdy=%b, want 1 1 5 beef 0 1",
               wb_valid, wb_en, wb_rd, wb_data, dmem_req, in_ready);
    end
  endtask

  task automatic test_store;
    in_valid = 1'b1; in_alusignals = 13'(1 << 2); in_result = 16'h0005; in_stdata = 16'hA5A5;
    in_rd = 3'd2; in_wben = 1'b1;
    tick();
    in_valid = 1'b0;
    vecs++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h05 || dmem_wdata !== 16'hA5A5 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL store_req: got req=%b we=%b addr=%h wd=%h wbv=%b, want 1 1 05 a5a5 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    vecs++;
    if ({wb_valid, wb_en, wb_data} !== {1'b1, 1'b0, 16'h0000} || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL store_retire: got v=%b en=%b d=%h req=%b, want 1 0 0000 0", wb_valid, wb_en, wb_data, dmem_req);
    end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; in_alusignals = 13'(1 << 1); in_result = 16'h0033; in_rd = 3'd1;
    tick();
    // sub is presented immediately and held until accepted
    in_alusignals = 13'(1 << 3); in_result = 16'h0F0F; in_rd = 3'd4; in_wben = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 16'h1234;
    vecs++;
    if (in_ready !== 1'b0 || dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_busy: got rdy=%b req=%b, want 0 1", in_ready, dmem_req);
    end
    tick();
    dmem_ack = 1'b0;
    vecs++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 3'd1, 16'h1234} || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_load: got v=%b en=%b rd=%0d d=%h rdy=%b, want 1 1 1 1234 1",
               wb_valid, wb_en, wb_rd, wb_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vecs++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 3'd4, 16'h0F0F}) begin
      miscompares++;
      $display("FAIL b2b_sub: got v=%b en=%b rd=%0d d=%h, want 1 1 4 0f0f", wb_valid, wb_en, wb_rd, wb_data);
    end
    tick();
    vecs++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_tail: got wbv=%b req=%b, want 0 0", wb_valid, dmem_req);
    end
  endtask

  task automatic test_random;
    int            kind;
    int            nwait;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_data;
    logic          exp_en;
    for (int a = 0; a < (1 << AW); a++) mem_model[a] = 16'($urandom);
    for (int op = 0; op < 60; op++) begin
      kind = $urandom_range(0, 3);
      in_result = 16'($urandom); in_stdata = 16'($urandom);
      in_rd = 3'($urandom); in_wben = 1'($urandom);
      case (kind)
        0:       in_alusignals = 13'(1 << (($urandom_range(0, 10) == 0) ? 0 : $urandom_range(3, 12)));
        1:       in_alusignals = 13'(1 << 1);
        2:       in_alusignals = 13'(1 << 2);
        default: in_alusignals = 13'b110;
      endcase
      in_valid = 1'b1;
      vecs++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd%0d_ready: got %b, want 1", op, in_ready);
      end
      tick();
      in_valid = 1'b0;
      if (kind == 0) begin
        exp_en = in_wben; exp_data = in_result;
      end else begin
        exp_addr = in_result[AW-1:0];
        exp_we   = (kind == 2);
        exp_en   = !exp_we;
        exp_data = exp_we ? 16'h0000 : mem_model[exp_addr];
        nwait    = $urandom_range(0, 4);
        for (int j = 0; j <= nwait; j++) begin
          vecs++;
          if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== exp_we ||
              (exp_we && dmem_wdata !== in_stdata) || in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd%0d_access: got req=%b addr=%h we=%b wd=%h rdy=%b wbv=%b, want 1 %h %b %h 0 0",
                     op, dmem_req, dmem_addr, dmem_we, dmem_wdata, in_ready, wb_valid, exp_addr, exp_we, in_stdata);
          end
          if (j == nwait) begin
            dmem_ack = 1'b1; dmem_rdata = mem_model[dmem_addr];
          end else begin
            dmem_rdata = 16'($urandom);
          end
          tick();
        end
        dmem_ack = 1'b0;
        if (exp_we) mem_model[exp_addr] = in_stdata;
      end
      vecs++;
      if ({wb_valid, wb_en, wb_rd, wb_data, err} !== {1'b1, exp_en, in_rd, exp_data, 1'b0}) begin
        miscompares++;
        $display("FAIL rnd%0d_retire: got v=%b en=%b rd=%0d d=%h err=%b, want 1 %b %0d %h 0",
                 op, wb_valid, wb_en, wb_rd, wb_data, err, exp_en, in_rd, exp_data);
      end
      if ($urandom_range(0, 2) == 0) begin
        dmem_ack = 1'($urandom);
        tick();
        dmem_ack = 1'b0;
        vecs++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rnd%0d_gap: got wbv=%b req=%b rdy=%b, want 0 0 1", op, wb_valid, dmem_req, in_ready);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int cyc;
    in_valid = 1'b1; in_alusignals = 13'(1 << 1); in_result = 16'h0077; in_rd = 3'd7;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (dmem_req === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    vecs++;
    if (cyc != TMO) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d req cycles, want %0d", cyc, TMO);
    end
    vecs++;
    if ({wb_valid, wb_en, wb_data, err} !== {1'b1, 1'b0, 16'h0000, 1'b1} || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_retire: got v=%b en=%b d=%h err=%b rdy=%b, want 1 0 0000 1 1",
               wb_valid, wb_en, wb_data, err, in_ready);
    end
    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
    tick();
    dmem_ack = 1'b0;
    tick();
    vecs++;
    if (wb_valid !== 1'b0 || err !== 1'b1 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_late_ack: got wbv=%b err=%b req=%b rdy=%b, want 0 1 0 1", wb_valid, err, dmem_req, in_ready);
    end
  endtask

  task automatic test_reset_mid_access;
    in_valid = 1'b1; in_alusignals = 13'(1 << 1); in_result = 16'h0010; in_rd = 3'd2;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_async: got req=%b wbv=%b err=%b rdy=%b, want 0 0 0 1", dmem_req, wb_valid, err, in_ready);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vecs++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_release: got req=%b wbv=%b err=%b rdy=%b, want 0 0 0 1", dmem_req, wb_valid, err, in_ready);
    end
  endtask

  initial begin
    vecs = 0;
    miscompares = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute ALU. It consumes the ALU result and the one-hot operation vector, and performs data-memory loads/stores over a req/ack handshake with variable latency.
- It presents a single-cycle writeback record to the register-file write stage.
- Non-memory operations pass through with 1-cycle latency. While a memory access is in flight, the stage back-pressures execute.

Parameters:
- DATA_W, 16, datapath width (matches the 16-bit ALU result).
- ADDR_W, 8, data-memory word-address width; uses in_result[ADDR_W-1:0].
- TIMEOUT_CYC, 64, maximum cycles dmem_req may stay high without dmem_ack before the access is aborted.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute has a valid result this cycle.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid & in_ready.
- in_alusignals  in  13  one-hot op vector; bit1 = isld, bit2 = isst.
- in_result  in  DATA_W  ALU result: effective address for ld/st, data otherwise.
- in_stdata  in  DATA_W  store data (rd register value) for st.
- in_rd  in  3  destination register index (8-entry register file).
- in_wben  in  1  writeback enable for non-memory ops.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  out  ADDR_W  word address; valid while dmem_req.
- dmem_wdata  out  DATA_W  store data; valid while dmem_req & dmem_we.
- dmem_ack  in  1  access complete this cycle; dmem_rdata valid on this cycle for loads.
- dmem_rdata  in  DATA_W  load data.
- wb_valid  out  1  one-cycle pulse: an instruction retires.
- wb_en  out  1  write wb_data to register wb_rd.
- wb_rd  out  3  destination index.
- wb_data  out  DATA_W  writeback value.
- err  out  1  sticky: a memory access timed out.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; dmem_req, dmem_we, wb_valid, wb_en, err = 0.
  - dmem_addr, dmem_wdata, wb_rd, wb_data = 0; timeout counter = 0.
  - in_ready = 1 immediately after reset release.
- States: IDLE, ACCESS.
- in_ready = 1 in IDLE, 0 in ACCESS (combinational from state).
- IDLE, transfer of a non-memory op (isld = isst = 0):
  - Next edge: wb_valid = 1, wb_en = in_wben, wb_rd = in_rd, wb_data = in_result.
  - State stays IDLE; throughput 1 op per cycle.
- IDLE, transfer of a memory op:
  - Latch dmem_addr = in_result[ADDR_W-1:0], dmem_wdata = in_stdata, dmem_we = isst & ~isld, wb_rd = in_rd.
  - Next edge: dmem_req = 1, state = ACCESS, counter = 0. wb_valid = 0 that cycle.
- Priority: if isld and isst are both set, the op is treated as a load. Upper address bits above ADDR_W are ignored.
- ACCESS:
  - dmem_req, addr, we and wdata held stable until the ack cycle; counter increments each cycle.
- dmem_ack seen in ACCESS, at the next edge:
  - dmem_req = 0, state = IDLE, wb_valid = 1.
  - Load: wb_en = 1, wb_data = dmem_rdata captured on the ack cycle.
  - Store: wb_en = 0, wb_data = 0.
- Latency for memory ops:
  - Accept at edge k; dmem_req high from k+1.
  - Ack in cycle k+1+n; wb_valid in cycle k+2+n.
  - Zero-wait ack (n = 0): 2 cycles accept-to-retire.
- Timeout: counter reaches TIMEOUT_CYC-1 with no ack → next edge:
  - dmem_req = 0, err = 1 (sticky until reset).
  - Retire with wb_valid = 1, wb_en = 0, wb_data = 0; state = IDLE.
- dmem_ack while in IDLE (late or spurious) is ignored.
- wb_valid is a pulse with no backpressure; the consumer must always accept it.
- A new transfer can be accepted in the same cycle wb_valid is high for the prior memory op.
- Reset asserted mid-access aborts immediately: dmem_req drops asynchronously and no retire occurs.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W = 16, REG_IDX_W = 3, ALU_SIG_W = 13.
  - Named alusignals bit indices (ADD = 0, LD = 1, ST = 2, … XOR = 12).
  - State enum {IDLE, ACCESS}.
- One natural sub-module, mem_timeout_ctr: clear/enable/expire counter of width $clog2(TIMEOUT_CYC); asynchronous active-low reset.

Test Plan:
- Reset then add (in_result = 16'h0012, in_rd = 3, in_wben = 1) → next cycle wb_valid = 1, wb_en = 1, wb_rd = 3, wb_data = 16'h0012; in_ready stays 1.
- Load with in_result = 16'h0140 (ADDR_W = 8), memory acks 3 cycles after req with rdata = 16'hBEEF:
  - dmem_addr = 8'h40 and dmem_we = 0 stable for 4 req cycles; in_ready = 0 during access.
  - Then wb_en = 1, wb_data = 16'hBEEF.
- Store with addr 16'h0005, in_stdata = 16'hA5A5, zero-wait ack:
  - dmem_we = 1, dmem_wdata = 16'hA5A5 for 1 cycle.
  - wb_valid = 1, wb_en = 0, 2 cycles after accept.
- Back-to-back: load (ack at n = 0) followed by sub held on in_valid:
  - sub accepted the cycle after the ack; retire order is load then sub, no lost or duplicated wb_valid.
- Load never acked, TIMEOUT_CYC = 64:
  - dmem_req drops after 64 cycles; err = 1 and stays 1.
  - wb_valid = 1 with wb_en = 0.
  - A later ack pulse is ignored.
- rst_n asserted 2 cycles into an access → dmem_req = 0 immediately, no wb_valid, err = 0, in_ready = 1 after release.
